// File: rtl/bus_server_ctrl.sv
// ============================================================================
// bus_server_ctrl : grants the arbiter's winner a burst and forwards the words
//                   through a one-deep registered output stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_server_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address_to_be_served,
  input  logic                  client_1_rq,
  input  logic                  client_2_rq,
  input  logic                  client_3_rq,
  input  logic                  client_4_rq,
  input  logic [DATA_WIDTH-1:0] client_1_data,
  input  logic [DATA_WIDTH-1:0] client_2_data,
  input  logic [DATA_WIDTH-1:0] client_3_data,
  input  logic [DATA_WIDTH-1:0] client_4_data,
  input  logic                  client_1_valid,
  input  logic                  client_2_valid,
  input  logic                  client_3_valid,
  input  logic                  client_4_valid,
  input  logic                  out_ready,
  output logic                  client_1_grant,
  output logic                  client_2_grant,
  output logic                  client_3_grant,
  output logic                  client_4_grant,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [1:0]            out_addr,
  output logic                  out_last,
  output logic                  server_ack,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    XFER  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cur_addr_q, cur_addr_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  abort_q, abort_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_addr_q, out_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic [3:0]            rq_vec;
  logic [3:0]            valid_vec;
  logic [DATA_WIDTH-1:0] data_arr [4];
  logic                  grant_en;
  logic                  beat;
  logic                  starve;
  logic [3:0]            grant_vec;

  assign rq_vec      = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};
  assign valid_vec   = {client_4_valid, client_3_valid, client_2_valid, client_1_valid};
  assign data_arr[0] = client_1_data;
  assign data_arr[1] = client_2_data;
  assign data_arr[2] = client_3_data;
  assign data_arr[3] = client_4_data;

  // A word may only be offered when the output stage is empty or draining.
  assign grant_en  = (state_q == XFER) & (~out_valid_q | out_ready);
  assign beat      = grant_en & valid_vec[cur_addr_q];
  assign starve    = grant_en & ~valid_vec[cur_addr_q];
  assign grant_vec = grant_en ? (4'b0001 << cur_addr_q) : 4'b0000;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beat_cnt_d = beat_cnt_q;
    to_cnt_d   = to_cnt_q;
    abort_d    = abort_q;
    case (state_q)
      IDLE: begin
        if (|rq_vec) state_d = LATCH;
      end
      LATCH: begin
        cur_addr_d = address_to_be_served;
        beat_cnt_d = '0;
        to_cnt_d   = '0;
        abort_d    = 1'b0;
        state_d    = rq_vec[address_to_be_served] ? XFER : IDLE;
      end
      XFER: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          to_cnt_d   = '0;
          if (beat_cnt_q == LAST_BEAT) state_d = ACK;
        end else if (starve) begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            state_d = ACK;
            abort_d = 1'b1;
          end
        end
      end
      ACK: begin
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (beat) begin
      out_data_d  = data_arr[cur_addr_q];
      out_addr_d  = cur_addr_q;
      out_valid_d = 1'b1;
      out_last_d  = (beat_cnt_q == LAST_BEAT);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      beat_cnt_q  <= '0;
      to_cnt_q    <= '0;
      abort_q     <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      to_cnt_q    <= to_cnt_d;
      abort_q     <= abort_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign client_1_grant = grant_vec[0];
  assign client_2_grant = grant_vec[1];
  assign client_3_grant = grant_vec[2];
  assign client_4_grant = grant_vec[3];
  assign out_data       = out_data_q;
  assign out_addr       = out_addr_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign server_ack     = (state_q == ACK);
  assign timeout_err    = (state_q == ACK) & abort_q;
  assign busy           = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bus_server_ctrl.sv
// ============================================================================
// tb_bus_server_ctrl : vector table plus directed sequences for bus_server_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_server_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic [3:0] rq;
  logic [3:0] vld;
  logic [7:0] cdata [4];
  logic       ready;
  logic [3:0] g;
  logic [7:0] od;
  logic       ov;
  logic [1:0] oa;
  logic       ol;
  logic       ack;
  logic       terr;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  bus_server_ctrl #(.DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .address_to_be_served(addr),
    .client_1_rq(rq[0]), .client_2_rq(rq[1]), .client_3_rq(rq[2]), .client_4_rq(rq[3]),
    .client_1_data(cdata[0]), .client_2_data(cdata[1]),
    .client_3_data(cdata[2]), .client_4_data(cdata[3]),
    .client_1_valid(vld[0]), .client_2_valid(vld[1]),
    .client_3_valid(vld[2]), .client_4_valid(vld[3]),
    .out_ready(ready),
    .client_1_grant(g[0]), .client_2_grant(g[1]), .client_3_grant(g[2]), .client_4_grant(g[3]),
    .out_data(od), .out_valid(ov), .out_addr(oa), .out_last(ol),
    .server_ack(ack), .timeout_err(terr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] vld;
    logic [1:0] addr;
    logic [7:0] data;
    logic       rdy;
    logic [3:0] e_g;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_oa;
    logic       e_ol;
    logic       e_ack;
    logic       e_busy;
    logic       e_terr;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] v, input logic [1:0] a,
                              input logic [7:0] d, input logic rd, input logic [3:0] eg,
                              input logic eov, input logic [7:0] eod, input logic [1:0] eoa,
                              input logic eol, input logic eack, input logic ebusy,
                              input logic eterr);
    vec_t x;
    x.rq = r; x.vld = v; x.addr = a; x.data = d; x.rdy = rd;
    x.e_g = eg; x.e_ov = eov; x.e_od = eod; x.e_oa = eoa; x.e_ol = eol;
    x.e_ack = eack; x.e_busy = ebusy; x.e_terr = eterr;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // The addressed client sees the intended word; all others see its complement.
  task automatic drive(input logic [3:0] r, input logic [3:0] v, input logic [1:0] a,
                       input logic [7:0] d, input logic rd);
    rq    = r;
    vld   = v;
    addr  = a;
    ready = rd;
    for (int n = 0; n < 4; n++) cdata[n] = (n == int'(a)) ? d : ~d;
  endtask

  task automatic burst(input int cid, input bit toggle, input logic [7:0] base);
    int         sent;
    int         rx;
    int         acks;
    logic       prev_stall;
    logic [7:0] prev_od;
    logic [3:0] sel;
    logic       rd;
    sent = 0; rx = 0; acks = 0; prev_stall = 1'b0; prev_od = 8'h00;
    sel = 4'b0001 << cid;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      rd = toggle ? (cyc % 2 == 0) : 1'b1;
      drive((sent == 0) ? sel : 4'b0000, sel, 2'(cid), base + 8'(sent), rd);
      #1;
      if (prev_stall) begin
        chk($sformatf("c%0d_stall_valid", cid), 32'(ov), 32'd1);
        chk($sformatf("c%0d_stall_hold", cid), 32'(od), 32'(prev_od));
      end
      if (ov && rd) begin
        chk($sformatf("c%0d_word%0d_data", cid, rx), 32'(od), 32'(base + 8'(rx)));
        chk($sformatf("c%0d_word%0d_addr", cid, rx), 32'(oa), 32'(cid));
        chk($sformatf("c%0d_word%0d_last", cid, rx), 32'(ol), 32'(rx == 3));
        rx++;
      end
      if (g != 4'b0000) chk($sformatf("c%0d_grant_sel", cid), 32'(g), 32'(sel));
      if (ack) begin
        acks++;
        chk($sformatf("c%0d_no_terr", cid), 32'(terr), 32'd0);
      end
      if ((g & sel) != 4'b0000) sent++;
      prev_stall = ov & ~rd;
      prev_od    = od;
      if (acks > 0 && !ov) break;
    end
    chk($sformatf("c%0d_words_out", cid), 32'(rx), 32'd4);
    chk($sformatf("c%0d_beats", cid), 32'(sent), 32'd4);
    chk($sformatf("c%0d_acks", cid), 32'(acks), 32'd1);
  endtask

  initial begin
    int beats;
    bit found;

    // Client 2 alone.
    tbl[0]  = mk(4'b0010, 4'b0010, 2'd1, 8'h10, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0010, 4'b0010, 2'd1, 8'h10, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 1, 0);
    tbl[2]  = mk(4'b0010, 4'b0010, 2'd1, 8'h10, 1'b1, 4'b0010, 0, 8'h00, 2'd0, 0, 0, 1, 0);
    tbl[3]  = mk(4'b0010, 4'b0010, 2'd1, 8'h11, 1'b1, 4'b0010, 1, 8'h10, 2'd1, 0, 0, 1, 0);
    tbl[4]  = mk(4'b0010, 4'b0010, 2'd1, 8'h12, 1'b1, 4'b0010, 1, 8'h11, 2'd1, 0, 0, 1, 0);
    tbl[5]  = mk(4'b0010, 4'b0010, 2'd1, 8'h13, 1'b1, 4'b0010, 1, 8'h12, 2'd1, 0, 0, 1, 0);
    tbl[6]  = mk(4'b0000, 4'b0000, 2'd1, 8'h00, 1'b1, 4'b0000, 1, 8'h13, 2'd1, 1, 1, 1, 0);
    tbl[7]  = mk(4'b0000, 4'b0000, 2'd1, 8'h00, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 0, 0);
    // Clients 1 and 4 together: client 1 first, then client 4.
    tbl[8]  = mk(4'b1001, 4'b1001, 2'd0, 8'h20, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 0, 0);
    tbl[9]  = mk(4'b1001, 4'b1001, 2'd0, 8'h20, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 1, 0);
    tbl[10] = mk(4'b1001, 4'b1001, 2'd0, 8'h20, 1'b1, 4'b0001, 0, 8'h00, 2'd0, 0, 0, 1, 0);
    tbl[11] = mk(4'b1001, 4'b1001, 2'd0, 8'h21, 1'b1, 4'b0001, 1, 8'h20, 2'd0, 0, 0, 1, 0);
    tbl[12] = mk(4'b1001, 4'b1001, 2'd0, 8'h22, 1'b1, 4'b0001, 1, 8'h21, 2'd0, 0, 0, 1, 0);
    tbl[13] = mk(4'b1001, 4'b1001, 2'd0, 8'h23, 1'b1, 4'b0001, 1, 8'h22, 2'd0, 0, 0, 1, 0);
    tbl[14] = mk(4'b1000, 4'b1000, 2'd0, 8'h00, 1'b1, 4'b0000, 1, 8'h23, 2'd0, 1, 1, 1, 0);
    tbl[15] = mk(4'b1000, 4'b1000, 2'd3, 8'h30, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 0, 0);
    tbl[16] = mk(4'b1000, 4'b1000, 2'd3, 8'h30, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 1, 0);
    tbl[17] = mk(4'b1000, 4'b1000, 2'd3, 8'h30, 1'b1, 4'b1000, 0, 8'h00, 2'd0, 0, 0, 1, 0);
    tbl[18] = mk(4'b1000, 4'b1000, 2'd3, 8'h31, 1'b1, 4'b1000, 1, 8'h30, 2'd3, 0, 0, 1, 0);
    tbl[19] = mk(4'b1000, 4'b1000, 2'd3, 8'h32, 1'b1, 4'b1000, 1, 8'h31, 2'd3, 0, 0, 1, 0);
    tbl[20] = mk(4'b1000, 4'b1000, 2'd3, 8'h33, 1'b1, 4'b1000, 1, 8'h32, 2'd3, 0, 0, 1, 0);
    tbl[21] = mk(4'b0000, 4'b0000, 2'd3, 8'h00, 1'b1, 4'b0000, 1, 8'h33, 2'd3, 1, 1, 1, 0);
    tbl[22] = mk(4'b0000, 4'b0000, 2'd3, 8'h00, 1'b1, 4'b0000, 0, 8'h00, 2'd0, 0, 0, 0, 0);

    reset = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_grant", 32'(g), 32'd0);
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_data", 32'(od), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(terr), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rq, tbl[i].vld, tbl[i].addr, tbl[i].data, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_grant", i), 32'(g), 32'(tbl[i].e_g));
      chk($sformatf("v%0d_valid", i), 32'(ov), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_last", i), 32'(ol), 32'(tbl[i].e_ol));
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_terr", i), 32'(terr), 32'(tbl[i].e_terr));
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_data", i), 32'(od), 32'(tbl[i].e_od));
        chk($sformatf("v%0d_addr", i), 32'(oa), 32'(tbl[i].e_oa));
      end
    end

    // Backpressure with out_ready toggling 1,0,1,0.
    burst(1, 1'b1, 8'h40);

    // Starved client 3: one beat, then valid held low until abort.
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(4'b0100, 4'b0100, 2'd2, 8'h77, 1'b1);
      #1;
      if (g[2]) begin
        found = 1'b1;
        break;
      end
    end
    chk("starve_first_grant", 32'(found), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drive(4'b0000, 4'b0000, 2'd2, 8'h00, 1'b1);
      #1;
      if (k == 1) begin
        chk("starve_word_valid", 32'(ov), 32'd1);
        chk("starve_word_data", 32'(od), 32'h77);
      end
      chk($sformatf("starve_k%0d_last", k), 32'(ol), 32'd0);
      if (k < 16) begin
        chk($sformatf("starve_k%0d_grant", k), 32'(g), 32'b0100);
        chk($sformatf("starve_k%0d_ack", k), 32'(ack), 32'd0);
      end else begin
        chk("starve_ack", 32'(ack), 32'd1);
        chk("starve_terr", 32'(terr), 32'd1);
      end
    end
    @(negedge clk);
    #1;
    chk("starve_idle_busy", 32'(busy), 32'd0);
    chk("starve_idle_terr", 32'(terr), 32'd0);

    // Request withdrawn before LATCH.
    @(negedge clk);
    drive(4'b0001, 4'b0000, 2'd0, 8'h00, 1'b1);
    #1;
    chk("wd_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 2'd0, 8'h00, 1'b1);
    #1;
    chk("wd_latch_busy", 32'(busy), 32'd1);
    chk("wd_latch_grant", 32'(g), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd_k%0d_busy", k), 32'(busy), 32'd0);
      chk($sformatf("wd_k%0d_grant", k), 32'(g), 32'd0);
      chk($sformatf("wd_k%0d_ack", k), 32'(ack), 32'd0);
    end

    // Reset mid-burst after two beats, then a clean full burst.
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(4'b0001, 4'b0001, 2'd0, 8'h60 + 8'(beats), 1'b1);
      #1;
      if (g[0]) beats++;
      if (beats == 2) break;
    end
    chk("mid_two_beats", 32'(beats), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(g), 32'd0);
    chk("mid_rst_valid", 32'(ov), 32'd0);
    chk("mid_rst_data", 32'(od), 32'd0);
    chk("mid_rst_addr", 32'(oa), 32'd0);
    chk("mid_rst_last", 32'(ol), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_terr", 32'(terr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    burst(0, 1'b0, 8'h80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
